// File: rtl/pe_group_acc.sv
// Dot-product PE group: TAPS signed MACs, adder tree, multi-pass group accumulator.
// Optional clamp-on-overflow accumulation when PE_GROUP_SAT_EN is defined.
module pe_group_acc #(
  parameter int TAPS  = 5,
  parameter int DW    = 8,
  parameter int ACC_W = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_load,
  input  logic [3:0]             w_idx,
  input  logic [DW-1:0]          w_data,
  input  logic [3:0]             cfg_passes,
  input  logic                   in_valid,
  input  logic [TAPS*DW-1:0]     ifmap_in,
  input  logic                   acc_clear,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       groupsum_out,
  output logic                   sat_flag
);

  localparam int PW = 2 * DW;

  logic signed [DW-1:0]    w    [TAPS];
  logic signed [DW-1:0]    ifm  [TAPS];
  logic signed [PW-1:0]    prod [TAPS];
  logic                    v1;
  logic                    v2;
  logic signed [ACC_W-1:0] tree;
  logic signed [ACC_W-1:0] sum2;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] total;
  logic [3:0]              cnt;
  logic [3:0]              passes_q;
  logic [3:0]              eff_cfg;
  logic [3:0]              npass;
  logic                    done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) w[i] <= '0;
    end else if (w_load) begin
      for (int i = 0; i < TAPS; i++)
        if (w_idx == 4'(i)) w[i] <= w_data;
    end
  end

  always_comb begin
    for (int i = 0; i < TAPS; i++) ifm[i] = ifmap_in[i*DW +: DW];
  end

  // Stage 1: per-tap products against the pre-write weights
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      for (int i = 0; i < TAPS; i++) prod[i] <= '0;
    end else begin
      v1 <= in_valid && !acc_clear;
      for (int i = 0; i < TAPS; i++)
        prod[i] <= PW'(ifm[i]) * PW'(w[i]);
    end
  end

  always_comb begin
    tree = '0;
    for (int i = 0; i < TAPS; i++) tree = tree + ACC_W'(prod[i]);
  end

  // Stage 2: adder tree
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2   <= 1'b0;
      sum2 <= '0;
    end else begin
      v2   <= v1 && !acc_clear;
      sum2 <= tree;
    end
  end

`ifdef PE_GROUP_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0] ext;
  logic                  ovf;

  always_comb begin
    ext     = {acc[ACC_W-1], acc} + {sum2[ACC_W-1], sum2};
    ovf     = ext[ACC_W] != ext[ACC_W-1];
    acc_sum = ovf ? (ext[ACC_W] ? MIN_V : MAX_V) : ext[ACC_W-1:0];
  end
`else
  always_comb acc_sum = acc + sum2;
`endif

  always_comb begin
    eff_cfg = (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
    npass   = (cnt == 4'd0) ? eff_cfg : passes_q;
    done    = (cnt + 4'd1) == npass;
    total   = (cnt == 4'd0) ? sum2 : acc_sum;
  end

  // Stage 3: group accumulator; an abort wins over the beat in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      passes_q     <= '0;
      acc          <= '0;
      groupsum_out <= '0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (acc_clear) begin
        cnt <= '0;
        acc <= '0;
      end else if (v2) begin
        passes_q <= npass;
        if (done) begin
          groupsum_out <= total;
          out_valid    <= 1'b1;
          cnt          <= '0;
          acc          <= '0;
        end else begin
          acc <= total;
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

`ifdef PE_GROUP_SAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sat_flag <= 1'b0;
    else if (!acc_clear && v2 && cnt != 4'd0 && ovf)
      sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_pe_group_acc.sv
// Bench for pe_group_acc: beat-level group model plus literal pins.
// Drives directed cases, then randomized traffic with weight writes and aborts.
module tb_pe_group_acc;
  localparam int TAPS  = 5;
  localparam int DW    = 8;
  localparam int ACC_W = 18;
  localparam longint MAXL = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint MINL = -(64'sd1 <<< (ACC_W-1));

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 w_load = 1'b0;
  logic [3:0]           w_idx = '0;
  logic [DW-1:0]        w_data = '0;
  logic [3:0]           cfg_passes = 4'd1;
  logic                 in_valid = 1'b0;
  logic [TAPS*DW-1:0]   ifmap_in = '0;
  logic                 acc_clear = 1'b0;
  logic                 out_valid;
  logic [ACC_W-1:0]     groupsum_out;
  logic                 sat_flag;

  pe_group_acc #(.TAPS(TAPS), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_idx(w_idx),
    .w_data(w_data), .cfg_passes(cfg_passes), .in_valid(in_valid),
    .ifmap_in(ifmap_in), .acc_clear(acc_clear), .out_valid(out_valid),
    .groupsum_out(groupsum_out), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  typedef struct { longint s; int t; } beat_t;
  typedef struct { int c; longint v; logic s; } lit_t;
  beat_t  pend[$];
  lit_t   lit[$];
  int     mw[TAPS];
  int     gcnt;
  int     gpass;
  longint gacc;
  logic   m_ov;
  longint m_gs;
  logic   m_sat;

  function automatic longint wrapv(longint x);
    logic signed [ACC_W-1:0] t;
    t = x[ACC_W-1:0];
    return longint'(t);
  endfunction

  function automatic longint beat_sum();
    longint s = 0;
    logic signed [DW-1:0] a;
    for (int i = 0; i < TAPS; i++) begin
      a = ifmap_in[i*DW +: DW];
      s += longint'(a) * longint'(mw[i]);
    end
    return s;
  endfunction

  function automatic logic [TAPS*DW-1:0] pk(int a0, int a1, int a2, int a3, int a4);
    logic [TAPS*DW-1:0] r;
    int a[TAPS];
    a = '{a0, a1, a2, a3, a4};
    for (int i = 0; i < TAPS; i++) r[i*DW +: DW] = DW'(a[i]);
    return r;
  endfunction

  task automatic model_reset();
    pend.delete();
    gcnt = 0; gpass = 1; gacc = 0;
    m_ov = 1'b0; m_gs = 0; m_sat = 1'b0;
    for (int i = 0; i < TAPS; i++) mw[i] = 0;
  endtask

  // Each valid beat joins its group two cycles after issue; result shows a cycle later
  task automatic model_step();
    longint s;
    longint r;
    m_ov = 1'b0;
    if (!rst) begin
      model_reset();
    end else begin
      if (acc_clear) begin
        pend.delete();
        gcnt = 0;
        gacc = 0;
      end else begin
        if (pend.size() > 0 && pend[0].t == cyc - 2) begin
          s = pend[0].s;
          pend.pop_front();
          if (gcnt == 0) begin
            gpass = (cfg_passes == 4'd0) ? 1 : int'(cfg_passes);
            gacc  = s;
          end else begin
            r = gacc + s;
`ifdef PE_GROUP_SAT_EN
            if (r > MAXL) begin r = MAXL; m_sat = 1'b1; end
            else if (r < MINL) begin r = MINL; m_sat = 1'b1; end
`else
            r = wrapv(r);
`endif
            gacc = r;
          end
          gcnt++;
          if (gcnt == gpass) begin
            m_ov = 1'b1; m_gs = gacc; gcnt = 0; gacc = 0;
          end
        end
        if (in_valid) pend.push_back('{beat_sum(), cyc});
      end
      if (w_load && int'(w_idx) < TAPS) mw[w_idx] = int'($signed(w_data));
    end
    cyc++;
  endtask

  always @(negedge clk) begin
    longint g;
    if (chk_on) begin
      g = longint'($signed(groupsum_out));
      tests++;
      if (out_valid !== m_ov) begin
        fails++;
        $display("FAIL out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, m_ov);
      end
      tests++;
      if (g != m_gs) begin
        fails++;
        $display("FAIL groupsum cyc=%0d got=%0d exp=%0d", cyc, g, m_gs);
      end
      tests++;
      if (sat_flag !== m_sat) begin
        fails++;
        $display("FAIL sat_flag cyc=%0d got=%0b exp=%0b", cyc, sat_flag, m_sat);
      end
      if (lit.size() > 0 && lit[0].c == cyc) begin
        tests++;
        if (out_valid !== 1'b1 || g != lit[0].v || sat_flag !== lit[0].s) begin
          fails++;
          $display("FAIL literal cyc=%0d got ov=%0b sum=%0d sat=%0b exp ov=1 sum=%0d sat=%0b",
                   cyc, out_valid, g, sat_flag, lit[0].v, lit[0].s);
        end
        void'(lit.pop_front());
      end else if (lit.size() > 0 && lit[0].c < cyc) begin
        tests++;
        fails++;
        $display("FAIL literal_missed cyc=%0d exp_cyc=%0d exp=%0d", cyc, lit[0].c, lit[0].v);
        void'(lit.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_w(int idx, int val);
    w_load = 1'b1; w_idx = 4'(idx); w_data = DW'(val);
    tick();
    w_load = 1'b0;
  endtask

  task automatic all_w(int val);
    for (int i = 0; i < TAPS; i++) set_w(i, val);
  endtask

  task automatic beat(logic [TAPS*DW-1:0] v);
    in_valid = 1'b1; ifmap_in = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pin(int dc, longint v, logic s);
    lit.push_back('{cyc + dc, v, s});
  endtask

  initial begin
    int c0;
    bit p1;
    bit p2;
    model_reset();
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(1);

    cfg_passes = 4'd1;
    all_w(1);
    pin(3, 15, 1'b0);
    beat(pk(1, 2, 3, 4, 5));
    idle(4);

    cfg_passes = 4'd3;
    c0 = cyc;
    lit.push_back('{c0 + 8, 30, 1'b0});
    beat(pk(1, 2, 3, 4, 0));
    idle(1);
    beat(pk(4, 3, 2, 1, 0));
    idle(2);
    beat(pk(2, 2, 2, 2, 2));
    idle(5);

    cfg_passes = 4'd1;
    pin(3, 5, 1'b0);
    w_load = 1'b1; w_idx = 4'd0; w_data = 8'd2;
    in_valid = 1'b1; ifmap_in = pk(1, 1, 1, 1, 1);
    tick();
    w_load = 1'b0;
    pin(3, 6, 1'b0);
    tick();
    in_valid = 1'b0;
    idle(4);

    set_w(0, 1);
    cfg_passes = 4'd2;
    beat(pk(1, 1, 1, 2, 2));
    idle(1);
    rst = 1'b0;
    model_reset();
    idle(2);
    rst = 1'b1;
    idle(1);
    all_w(1);
    pin(4, 14, 1'b0);
    beat(pk(1, 1, 1, 2, 2));
    beat(pk(2, 2, 1, 1, 1));
    idle(4);

    beat(pk(1, 1, 1, 1, 0));
    idle(3);
    acc_clear = 1'b1;
    beat(pk(1, 1, 1, 1, 0));
    acc_clear = 1'b0;
    idle(3);
    pin(4, 8, 1'b0);
    beat(pk(1, 1, 1, 1, 0));
    beat(pk(0, 1, 1, 1, 1));
    idle(4);

    all_w(-128);
`ifdef PE_GROUP_SAT_EN
    pin(4, 131071, 1'b1);
`else
    pin(4, -98304, 1'b0);
`endif
    beat(pk(-128, -128, -128, -128, -128));
    beat(pk(-128, -128, -128, -128, -128));
    idle(4);

    p1 = 1'b0;
    p2 = 1'b0;
    for (int seg = 0; seg < 4; seg++) begin
      idle(4);
      cfg_passes = 4'($urandom_range(0, 4));
      for (int n = 0; n < 200; n++) begin
        in_valid = ($urandom_range(0, 9) < 7);
        for (int i = 0; i < TAPS; i++) ifmap_in[i*DW +: DW] = DW'($urandom);
        w_load = ($urandom_range(0, 9) == 0);
        w_idx  = 4'($urandom_range(0, 7));
        w_data = DW'($urandom);
        acc_clear = !p1 && !p2 && ($urandom_range(0, 29) == 0);
        tick();
        p2 = p1;
        p1 = in_valid && !acc_clear;
      end
      in_valid = 1'b0;
      w_load = 1'b0;
      acc_clear = 1'b0;
      p1 = 1'b0;
      p2 = 1'b0;
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_group_acc.md
PE_GROUP_ACC -- requirements
Module: pe_group_acc

Interface
REQ-001 SHALL provide parameter TAPS, default 5, number of multiplier taps (1..16).
REQ-002 SHALL provide parameter DW, default 8, signed width of each ifmap and weight element.
REQ-003 SHALL provide parameter ACC_W, default 24, signed accumulator and output width (ACC_W >= 2*DW+clog2(TAPS)).
REQ-004 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide port w_load  input  1  weight write strobe.
REQ-007 SHALL provide port w_idx  input  4  target tap index for the weight write.
REQ-008 SHALL provide port w_data  input  DW  signed weight value for the write.
REQ-009 SHALL provide port cfg_passes  input  4  valid inputs per output group; 0 is treated as 1.
REQ-010 SHALL provide port in_valid  input  1  ifmap vector valid (successor of calculate_en).
REQ-011 SHALL provide port ifmap_in  input  TAPS*DW  packed signed ifmaps; tap i occupies bits [i*DW +: DW].
REQ-012 SHALL provide port acc_clear  input  1  synchronous abort of the partial group.
REQ-013 SHALL provide port out_valid  output  1  one-cycle pulse marking a completed group sum.
REQ-014 SHALL provide port groupsum_out  output  ACC_W  signed group sum, held until the next out_valid.
REQ-015 SHALL provide port sat_flag  output  1  sticky saturation indicator.

Function
REQ-016 SHALL write w_data into weight register w_idx when w_load=1; w_idx >= TAPS is ignored; weights hold until rewritten or reset.
REQ-017 SHALL use the pre-write weight for an in_valid beat in the same cycle as a w_load to that tap.
REQ-018 Stage 1 SHALL register prod[i] = ifmap[i]*w[i] (signed, 2*DW bits) and v1 <= in_valid.
REQ-019 Stage 2 SHALL register the sign-extended sum of all TAPS products at ACC_W bits and v2 <= v1.
REQ-020 Stage 3 SHALL, when v2=1, add the stage-2 sum into the accumulator; the first beat of a group loads the sum and does not add it.
REQ-021 SHALL count valid beats with a pass counter and latch cfg_passes at each group's first beat; mid-group changes take effect on the next group.
REQ-022 SHALL, on the beat completing the group, register groupsum_out = final total, pulse out_valid, and reset counter and accumulator for the next group.
REQ-023 Latency SHALL be 3 cycles from the last in_valid beat of a group to out_valid; in_valid gaps are allowed, and only valid beats count.
REQ-024 SHALL accept one beat per cycle with no back-pressure.
REQ-025 acc_clear=1 SHALL zero v1, v2, the counter and the accumulator; an in_valid beat in the same cycle is dropped; groupsum_out and sat_flag are kept.

Reset
REQ-026 rst=0 SHALL asynchronously clear all weights, prods, stage sums, v1, v2, the counter, the accumulator, groupsum_out, out_valid and sat_flag to 0.
REQ-027 rst asserted mid-group SHALL discard the partial group; the first valid beat after release starts a new group.

Configuration
REQ-028 With PE_GROUP_SAT_EN defined, accumulation SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set sat_flag on any clamp; sat_flag is cleared only by rst.
REQ-029 Without PE_GROUP_SAT_EN, accumulation SHALL wrap modulo 2^ACC_W and sat_flag SHALL be constant 0.

Verification
REQ-030 TAPS=5, all weights 1, ifmap 1..5, cfg_passes=1, one beat at cycle 0 -> out_valid at cycle 3, groupsum_out=15.
REQ-031 cfg_passes=3, beats each summing 10 at cycles 0, 2, 5 -> exactly one out_valid at cycle 8, groupsum_out=30.
REQ-032 ACC_W=18, weights and ifmaps all -128, cfg_passes=2 -> with PE_GROUP_SAT_EN: 131071, sat_flag=1; without it: -98304, sat_flag=0.
REQ-033 w_load tap 0 to 2 in the same cycle as a beat with weights=1 and ifmap all 1 -> that sum is 5; the next identical beat's sum is 6.
REQ-034 rst pulsed after beat 1 of a cfg_passes=2 group, then two beats summing 7 -> all outputs are 0 during reset, then groupsum_out=14.
REQ-035 acc_clear together with beat 2 of a cfg_passes=2 group, then two beats summing 4 -> no out_valid for the aborted group, then groupsum_out=8.
